// File: rtl/fht_pkg.sv
// fht_pkg: FSM encoding, default pipeline latency and log2 helper shared by the FHT blocks
package fht_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fht_state_t;
   localparam int PIPE_LAT_DEF = 3;
   function automatic int log2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fht_addr_dly.sv
// fht_addr_dly: DEPTH-stage shift register with synchronous active-high clear
module fht_addr_dly #(
   parameter int W     = 9,
   parameter int DEPTH = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] sr [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) sr <= '{default: '0};
      else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/fht_but_feeder.sv
// fht_but_feeder: sequences read/twiddle/write addressing for a ping-pong radix-2 FHT
module fht_but_feeder
   import fht_pkg::*;
#(
   parameter int A_BIT    = 4,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
   output logic             oRD_EN,
   output logic [A_BIT-1:0] oRD_ADDR_0,
   output logic [A_BIT-1:0] oRD_ADDR_1,
   output logic [A_BIT-1:0] oRD_ADDR_2,
   output logic [A_BIT-2:0] oROM_ADDR,
   output logic             oRD_BANK,
   output logic             oWR_EN,
   output logic [A_BIT-1:0] oWR_ADDR_0,
   output logic [A_BIT-1:0] oWR_ADDR_1,
   output logic             oWR_BANK,
   output logic [A_BIT-1:0] oSTAGE,
   output logic             oBUSY,
   output logic             oDONE,
   output logic             oRES_BANK
);
   localparam int DW = log2(PIPE_LAT + 1);
   localparam logic [A_BIT-1:0] S_LAST = A_BIT'(A_BIT - 1);
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
   fht_state_t st, st_n;
   logic [A_BIT-2:0] b, b_n, msk, k, rom;
   logic [A_BIT-1:0] s, s_n, h, g, a0, a1, a2;
   logic [DW-1:0] d, d_n;
   logic run_n, busy_n;
   always_comb begin
      st_n = st;
      b_n  = b;
      s_n  = s;
      d_n  = d;
      case (st)
         IDLE: if (iSTART) begin
            st_n = RUN;
            b_n  = '0;
            s_n  = '0;
         end
         RUN: if (&b) begin
            st_n = DRAIN;
            d_n  = '0;
         end else b_n = b + 1'b1;
         DRAIN: if (d == D_LAST) begin
            if (s == S_LAST) st_n = DONE;
            else begin
               st_n = RUN;
               s_n  = s + 1'b1;
               b_n  = '0;
            end
         end else d_n = d + 1'b1;
         default: st_n = IDLE;
      endcase
   end
   // addresses are formed from the next-cycle counters so the registered outputs line up with oRD_EN
   always_comb begin
      h   = A_BIT'(1) << s_n;
      msk = h[A_BIT-2:0] - 1'b1;
      k   = b_n & msk;
      g   = {b_n >> s_n, 1'b0} << s_n;
      a0  = g + {1'b0, k};
      a1  = a0 + h;
      a2  = g + h + {1'b0, (h[A_BIT-2:0] - k) & msk};
      rom = k << (S_LAST - s_n);
   end
   assign run_n  = st_n == RUN;
   assign busy_n = run_n || st_n == DRAIN;
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         st         <= IDLE;
         b          <= '0;
         s          <= '0;
         d          <= '0;
         oRD_EN     <= 1'b0;
         oRD_ADDR_0 <= '0;
         oRD_ADDR_1 <= '0;
         oRD_ADDR_2 <= '0;
         oROM_ADDR  <= '0;
         oRD_BANK   <= 1'b0;
         oWR_BANK   <= 1'b0;
         oSTAGE     <= '0;
         oBUSY      <= 1'b0;
         oDONE      <= 1'b0;
      end else begin
         st         <= st_n;
         b          <= b_n;
         s          <= s_n;
         d          <= d_n;
         oRD_EN     <= run_n;
         oRD_ADDR_0 <= run_n ? a0 : '0;
         oRD_ADDR_1 <= run_n ? a1 : '0;
         oRD_ADDR_2 <= run_n ? a2 : '0;
         oROM_ADDR  <= run_n ? rom : '0;
         oRD_BANK   <= busy_n & s_n[0];
         oWR_BANK   <= busy_n & ~s_n[0];
         oSTAGE     <= busy_n ? s_n : '0;
         oBUSY      <= busy_n;
         oDONE      <= st_n == DONE;
      end
   end
   fht_addr_dly #(.W(2*A_BIT + 1), .DEPTH(PIPE_LAT)) u_dly (
      .clk(iCLK),
      .rst(iRESET),
      .d  ({oRD_EN, oRD_ADDR_0, oRD_ADDR_1}),
      .q  ({oWR_EN, oWR_ADDR_0, oWR_ADDR_1})
   );
   assign oRES_BANK = 1'(A_BIT % 2);
endmodule

// File: tb/tb_fht_but_feeder.sv
// tb_fht_but_feeder: scoreboard bench for the FHT butterfly address sequencer (A_BIT=4, PIPE_LAT=3)
module tb_fht_but_feeder;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic rd_en, rd_bank, wr_en, wr_bank, busy, done, res_bank;
   logic [3:0] rd_a0, rd_a1, rd_a2, wr_a0, wr_a1, stage;
   logic [2:0] rom;
   int checks = 0, errors = 0, cyc = 0, wr_tot = 0;
   typedef struct packed {logic [3:0] a0, a1, a2; logic [2:0] rom; logic bank; logic [3:0] stage;} rd_t;
   typedef struct packed {logic [3:0] a0, a1; logic bank;} wr_t;
   typedef struct {int s, b, a0, a1, a2, rom;} hv_t;
   rd_t rd_q[$];
   wr_t wr_q[$];
   int rd_cyc[$];
   hv_t hand [6] = '{'{0, 3, 6, 7, 7, 0}, '{1, 0, 0, 2, 2, 0}, '{1, 3, 5, 7, 7, 4},
                     '{2, 5, 9, 13, 15, 2}, '{3, 0, 0, 8, 8, 0}, '{3, 7, 7, 15, 9, 7}};
   fht_but_feeder #(.A_BIT(4), .PIPE_LAT(3)) dut (
      .iCLK(clk), .iRESET(rst), .iSTART(start),
      .oRD_EN(rd_en), .oRD_ADDR_0(rd_a0), .oRD_ADDR_1(rd_a1), .oRD_ADDR_2(rd_a2),
      .oROM_ADDR(rom), .oRD_BANK(rd_bank), .oWR_EN(wr_en), .oWR_ADDR_0(wr_a0),
      .oWR_ADDR_1(wr_a1), .oWR_BANK(wr_bank), .oSTAGE(stage), .oBUSY(busy),
      .oDONE(done), .oRES_BANK(res_bank)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // expected stream: generic index model, overridden by hand-worked vectors
   task automatic push_exp();
      for (int s = 0; s < 4; s++)
         for (int b = 0; b < 8; b++) begin
            int h, g, k, a0, a1, a2, r;
            h = 1 << s;
            g = (b / h) * 2 * h;
            k = b % h;
            a0 = g + k;
            a1 = g + h + k;
            a2 = g + h + (h - k) % h;
            r = k * (8 / h);
            foreach (hand[i])
               if (hand[i].s == s && hand[i].b == b) begin
                  a0 = hand[i].a0; a1 = hand[i].a1; a2 = hand[i].a2; r = hand[i].rom;
               end
            rd_q.push_back(rd_t'{4'(a0), 4'(a1), 4'(a2), 3'(r), 1'(s % 2), 4'(s)});
            wr_q.push_back(wr_t'{4'(a0), 4'(a1), 1'(1 - s % 2)});
         end
   endtask
   int rd_n = 0, wr_n = 0, gap = 0;
   always @(negedge clk) begin
      cyc++;
      if (!busy) begin
         rd_n = 0; wr_n = 0; gap = 0;
         if (!wr_en) rd_cyc.delete();
      end else begin
         if (rd_en) begin
            if (rd_n > 0 && rd_n % 8 == 0) begin
               chk("stage_gap", gap, 3);
               chk("stage_writes_done", wr_n, rd_n);
            end
            gap = 0;
            if (rd_q.size() > 0) begin
               rd_t e;
               e = rd_q.pop_front();
               chk("rd", {rd_a0, rd_a1, rd_a2, rom, rd_bank, stage}, e);
            end else chk("rd_unexpected", rd_en, 0);
            rd_cyc.push_back(cyc);
            rd_n++;
         end else gap++;
         chk("bank_complement", wr_bank, !rd_bank);
      end
      if (wr_en) begin
         if (wr_q.size() > 0) begin
            wr_t e;
            e = wr_q.pop_front();
            chk("wr", {wr_a0, wr_a1, wr_bank}, e);
         end else chk("wr_unexpected", wr_en, 0);
         if (rd_cyc.size() > 0) chk("wr_latency", cyc - rd_cyc.pop_front(), 3);
         else chk("wr_without_rd", wr_en, 0);
         wr_n++;
         wr_tot++;
      end
   end
   function automatic logic [63:0] all_out();
      return {rd_en, rd_a0, rd_a1, rd_a2, rom, rd_bank, wr_en, wr_a0, wr_a1, wr_bank,
              stage, busy, done, res_bank};
   endfunction
   task automatic run_tf(input bit restart);
      int cnt, w0;
      push_exp();
      w0 = wr_tot;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cnt = 1;
      chk("busy_rise", busy, 1);
      while (!done && cnt < 100) begin
         start = restart && (cnt == 5 || cnt == 30);
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      chk("done_latency", cnt, 45);
      chk("wr_count", wr_tot - w0, 32);
      chk("busy_in_done", busy, 0);
      chk("res_bank", res_bank, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("queues_drained", rd_q.size() + wr_q.size(), 0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_out(), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", all_out(), 0);
      run_tf(1'b0);
      repeat (2) @(negedge clk);
      run_tf(1'b1);
      begin
         int cnt;
         push_exp();
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
         cnt = 1;
         while (cnt < 15) begin
            @(negedge clk);
            cnt++;
         end
         chk("mid_stage1", stage, 1);
         rst = 1'b1;
         @(negedge clk);
         chk("abort_outputs", all_out(), 0);
         rst = 1'b0;
         rd_q.delete();
         wr_q.delete();
         repeat (3) begin
            @(negedge clk);
            chk("no_wr_after_reset", wr_en, 0);
         end
      end
      run_tf(1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule
